imem_fetch_responder: RTL

Instruction-memory responder for the IF stage. It accepts the fetch address driven by the PC register, reads a word from an internal instruction store over LATENCY cycles, and returns the instruction with a one-cycle valid pulse. While a fetch is outstanding it drives stall back to the PC, so the PC holds its address until the memory has served it. It also provides a program-load write port and a flush input for branch/jump redirects.

---
 rtl/imem_fetch_responder.sv | 107 ++++++++++
 1 files changed

// File: rtl/imem_fetch_responder.sv
// rtl/imem_fetch_responder.sv - IF-stage instruction memory responder
// Fixed-latency fetch from an internal store, with PC stall, flush and a program-load port.
module imem_fetch_responder #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int DEPTH_WORDS = 256,
  parameter  int LATENCY     = 2,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic                  flush,
  output logic                  stall,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_instr,
  output logic [DATA_WIDTH-1:0] rsp_addr,
  output logic                  rsp_err,
  input  logic                  load_en,
  input  logic [IDX_W-1:0]      load_addr,
  input  logic [DATA_WIDTH-1:0] load_data
);

  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic                  w_accept;
  logic                  w_complete;
  logic                  w_err;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_hi;

  // Anything above the word-index field must be zero, as must the byte offset.
  assign w_idx = r_addr[IDX_W+1:2];
  assign w_hi  = r_addr >> (IDX_W + 2);
  assign w_err = (r_addr[1:0] != 2'b00) || (w_hi != '0);

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_complete   = 1'b0;
    stall        = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid && !flush && !load_en) begin
          w_accept     = 1'b1;
          w_next_state = BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          w_next_state = IDLE;
        end else if (r_cnt == '0) begin
          w_complete   = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
    // Drop stall in the last busy cycle so the PC advances as the response registers.
    if (reset && req_valid && !flush)
      stall = (r_state == IDLE) || (r_cnt != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      rsp_valid <= 1'b0;
      rsp_instr <= '0;
      rsp_addr  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      rsp_valid <= w_complete;
      if (w_accept) begin
        r_addr <= req_addr;
        r_cnt  <= CNT_W'(LATENCY - 1);
      end else if (r_state == BUSY && !flush && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_complete) begin
        rsp_addr  <= r_addr;
        rsp_err   <= w_err;
        rsp_instr <= w_err ? '0 : r_mem[w_idx];
      end
    end
  end

  // Store is never cleared; a same-edge write is not visible to the final read.
  always_ff @(posedge clk) begin
    if (load_en)
      r_mem[load_addr] <= load_data;
  end

endmodule
